// File: rtl/bomb_sequencer.sv
// bomb_sequencer: life-cycle FSM, prescaler and defuse logic for the countdown bomb
module bomb_sequencer #(
    parameter int         CLK_DIV     = 100000000,
    parameter int         START_VALUE = 15,
    parameter logic [3:0] DEFUSE_CODE = 4'hA,
    parameter int         MAX_TRIES   = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Code_Valid,
    input  logic [3:0] Code_In,
    input  logic [4:0] Count_In,
    output logic       Counter_Load,
    output logic [4:0] Load_Value,
    output logic       Counter_Dec,
    output logic       Blow_Up,
    output logic       Defused,
    output logic [2:0] State_Out
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] TOP = PW'(CLK_DIV - 1);
    localparam logic [3:0] MAX = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSE   = 3'd2,
        DEFUSED = 3'd3,
        BOOM    = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc;
    logic [3:0]    tries, tries_n, tries_inc;
    logic          start_prev, stop_prev, start_evt, stop_evt;
    logic          tick, code_ok, code_bad, load_n, dec_n;

    assign start_evt  = Start & ~start_prev;
    assign stop_evt   = Stop & ~stop_prev;
    assign tick       = (state == RUN) && (presc == TOP);
    assign code_ok    = Code_Valid && (Code_In == DEFUSE_CODE);
    assign code_bad   = Code_Valid && !code_ok;
    assign tries_inc  = tries + 4'd1;
    assign Load_Value = 5'(START_VALUE);
    assign Blow_Up    = (state == BOOM);
    assign Defused    = (state == DEFUSED);
    assign State_Out  = state;

    // next state, tries and counter strobes by priority
    always_comb begin
        state_n = state;
        tries_n = tries;
        load_n  = 1'b0;
        dec_n   = 1'b0;
        case (state)
            IDLE: if (start_evt && !stop_evt) begin
                load_n  = 1'b1;
                tries_n = 4'd0;
                state_n = RUN;
            end
            RUN, PAUSE: begin
                if (code_ok) state_n = DEFUSED;
                else if (tick && Count_In <= 5'd1) begin
                    dec_n   = (Count_In == 5'd1);
                    state_n = BOOM;
                end else if (code_bad && tries_inc == MAX) begin
                    tries_n = tries_inc;
                    state_n = BOOM;
                end else begin
                    tries_n = code_bad ? tries_inc : tries;
                    dec_n   = tick;
                    if (state == RUN && stop_evt) state_n = PAUSE;
                    else if (state == PAUSE && start_evt && !stop_evt) state_n = RUN;
                end
            end
            default: ;
        endcase
    end

    // state, edge detectors, registered strobes and prescaler
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            tries        <= 4'd0;
            start_prev   <= 1'b0;
            stop_prev    <= 1'b0;
            Counter_Load <= 1'b0;
            Counter_Dec  <= 1'b0;
            presc        <= '0;
        end else begin
            state        <= state_n;
            tries        <= tries_n;
            start_prev   <= Start;
            stop_prev    <= Stop;
            Counter_Load <= load_n;
            Counter_Dec  <= dec_n;
            presc        <= load_n ? '0 : (state == RUN) ? (tick ? '0 : presc + PW'(1)) : presc;
        end
    end
endmodule

// File: tb/tb_bomb_sequencer.sv
// tb_bomb_sequencer: directed checks of countdown, pause, defuse, wrong codes and reset
module tb_bomb_sequencer;
    logic       clk, Reset, Start, Stop, Code_Valid;
    logic [3:0] Code_In;
    logic [4:0] cnt;
    logic       Counter_Load, Counter_Dec, Blow_Up, Defused;
    logic [4:0] Load_Value;
    logic [2:0] State_Out;
    int vectors = 0, miscompares = 0;
    int cyc = 0, load_cnt = 0, load_cyc = 0, dec_cnt = 0, rc = 0;
    int dec_at [1:16];

    bomb_sequencer #(.CLK_DIV(4), .START_VALUE(15), .DEFUSE_CODE(4'hA), .MAX_TRIES(3)) dut (
        .Clock(clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Code_Valid(Code_Valid),
        .Code_In(Code_In), .Count_In(cnt), .Counter_Load(Counter_Load), .Load_Value(Load_Value),
        .Counter_Dec(Counter_Dec), .Blow_Up(Blow_Up), .Defused(Defused), .State_Out(State_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external 5-bit down-counter
    always @(posedge clk) begin
        if (Counter_Load) cnt <= Load_Value;
        else if (Counter_Dec) cnt <= cnt - 5'd1;
    end

    // event monitor, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (Counter_Load) begin
            load_cnt++;
            load_cyc = cyc;
        end
        if (Counter_Dec) begin
            dec_cnt++;
            if (dec_cnt <= 16) dec_at[dec_cnt] = cyc;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_dec(input int n, input string tag);
        int t = 0;
        while (dec_cnt < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(tag, int'(dec_cnt >= n), 1);
    endtask

    task automatic wait_boom(input string tag);
        int t = 0;
        while (!Blow_Up && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(tag, int'(Blow_Up), 1);
    endtask

    task automatic do_reset(input string tag);
        #2 Reset = 1'b0;
        #1 chk(tag, int'({Counter_Load, Counter_Dec, Blow_Up, Defused, State_Out}), 0);
        @(negedge clk);
        Start = 0; Stop = 0; Code_Valid = 0; Code_In = 0;
        Reset = 1'b1;
        load_cnt = 0; dec_cnt = 0;
    endtask

    task automatic start_run(input string tag);
        Start = 1'b1;
        @(negedge clk);
        chk(tag, int'({Counter_Load, State_Out}), 4'b1001);
        Start = 1'b0;
    endtask

    task automatic code(input logic [3:0] c);
        Code_Valid = 1'b1;
        Code_In = c;
        @(negedge clk);
        Code_Valid = 1'b0;
    endtask

    initial begin
        Reset = 0; Start = 0; Stop = 0; Code_Valid = 0; Code_In = 0;
        #3;
        chk("reset_outputs", int'({Counter_Load, Counter_Dec, Blow_Up, Defused, State_Out}), 0);
        chk("load_value", int'(Load_Value), 15);
        @(negedge clk);
        Reset = 1;
        @(negedge clk);

        // full countdown
        start_run("a_load");
        wait_boom("a_boom_seen");
        chk("a_dec_count", dec_cnt, 15);
        chk("a_first_dec", dec_at[1] - load_cyc, 4);
        chk("a_last_dec", dec_at[15] - load_cyc, 60);
        chk("a_boom_with_dec", int'(Counter_Dec), 1);
        chk("a_state", int'(State_Out), 4);
        repeat (5) @(negedge clk);
        chk("a_boom_held", int'({Blow_Up, Counter_Dec}), 2'b10);

        // pause / resume
        do_reset("b_reset");
        start_run("b_load");
        wait_dec(3, "b_dec3");
        @(negedge clk);
        Stop = 1;
        @(negedge clk);
        Stop = 0;
        chk("b_paused", int'(State_Out), 2);
        repeat (20) @(negedge clk);
        chk("b_no_dec_in_pause", dec_cnt, 3);
        Start = 1;
        @(negedge clk);
        Start = 0;
        chk("b_resumed", int'(State_Out), 1);
        rc = cyc;
        wait_dec(4, "b_dec4");
        chk("b_dec4_after_resume", dec_at[4] - rc, 2);
        wait_boom("b_boom_seen");
        chk("b_dec_count", dec_cnt, 15);

        // defuse with Count_In=7
        do_reset("c_reset");
        start_run("c_load");
        wait_dec(8, "c_dec8");
        @(negedge clk);
        chk("c_count7", int'(cnt), 7);
        code(4'hA);
        chk("c_defused", int'({Defused, Blow_Up, State_Out}), 5'b10011);
        Start = 1; Stop = 1;
        repeat (3) @(negedge clk);
        Start = 0; Stop = 0;
        repeat (3) @(negedge clk);
        Start = 1;
        repeat (20) @(negedge clk);
        Start = 0;
        chk("c_no_more_dec", dec_cnt, 8);
        chk("c_no_reload", load_cnt, 1);
        chk("c_still_defused", int'(State_Out), 3);

        // three wrong codes
        do_reset("d_reset");
        start_run("d_load");
        code(4'h3);
        @(negedge clk);
        code(4'h3);
        chk("d_two_wrong", int'({Blow_Up, State_Out}), 4'b0001);
        @(negedge clk);
        code(4'h3);
        chk("d_third_wrong", int'({Blow_Up, State_Out}), 4'b1100);

        // two wrong then correct
        do_reset("e_reset");
        start_run("e_load");
        code(4'h3);
        code(4'h3);
        code(4'hA);
        chk("e_defused", int'({Defused, Blow_Up, State_Out}), 5'b10011);

        // correct code on final tick
        do_reset("f_reset");
        start_run("f_load");
        wait_dec(14, "f_dec14");
        repeat (3) @(negedge clk);
        code(4'hA);
        chk("f_defused_not_boom", int'({Defused, Blow_Up, State_Out}), 5'b10011);
        chk("f_no_final_dec", dec_cnt, 14);

        // Start and Stop together in IDLE
        do_reset("g_reset");
        Start = 1; Stop = 1;
        @(negedge clk);
        chk("g_stay_idle", int'({Counter_Load, State_Out}), 0);
        Start = 0; Stop = 0;
        repeat (3) @(negedge clk);
        chk("g_no_load", load_cnt, 0);

        // async reset mid-run, then fresh full sequence
        start_run("h_load");
        code(4'h3);
        code(4'h3);
        wait_dec(6, "h_dec6");
        @(negedge clk);
        chk("h_count9", int'(cnt), 9);
        do_reset("h_async_reset");
        start_run("h_reload");
        code(4'h3);
        chk("h_tries_cleared", int'({Blow_Up, State_Out}), 4'b0001);
        wait_boom("h_boom_seen");
        chk("h_dec_count", dec_cnt, 15);
        chk("h_last_dec", dec_at[15] - load_cyc, 60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
